// File: rtl/pool2_pkg.sv
// Shared defaults and FSM state encoding for the 2-D max-pool window engine.
package pool2_pkg;

    localparam int IN_W_D   = 27;
    localparam int K_D      = 3;
    localparam int S_D      = 2;
    localparam int OUT_W_D  = (IN_W_D - K_D) / S_D + 1;
    localparam int DATA_W_D = 16;
    localparam int ADDR_W_D = 10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/pool2_row_offset.sv
// Row base address: unsigned row index times the feature-map width,
// truncated to the buffer address width.
module pool2_row_offset
    import pool2_pkg::*;
#(
    parameter int IN_W   = IN_W_D,
    parameter int ADDR_W = ADDR_W_D,
    parameter int ROW_W  = 8
) (
    input  logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] base
);

    always_comb begin
        base = ADDR_W'(32'(row) * 32'(IN_W));
    end

endmodule

// File: rtl/pool2_window_max.sv
// Strided KxK max-pool over a square feature map held in an external
// single-cycle-latency read buffer; one window maximum emitted per handshake.
module pool2_window_max
    import pool2_pkg::*;
#(
    parameter int IN_W   = IN_W_D,
    parameter int K      = K_D,
    parameter int S      = S_D,
    parameter int OUT_W  = OUT_W_D,
    parameter int DATA_W = DATA_W_D,
    parameter int ADDR_W = ADDR_W_D
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              ap_done,
    output logic [ADDR_W-1:0] in_addr,
    output logic              in_ce,
    input  logic [DATA_W-1:0] in_q,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_idx,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [7:0] KM1 = 8'(K - 1);
    localparam logic [7:0] OM1 = 8'(OUT_W - 1);

    state_t state, state_nx;

    logic [7:0]               oh, ow, kh, kw, idx;
    logic [7:0]               row;
    logic [ADDR_W-1:0]        row_base;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     rd_vld, rd_first;
    logic signed [DATA_W-1:0] mx;
    logic                     win_last, frame_last;

    assign row        = 8'(32'(oh) * 32'(S) + 32'(kh));
    assign rd_addr    = row_base + ADDR_W'(32'(ow) * 32'(S) + 32'(kw));
    assign win_last   = (kh == KM1) && (kw == KM1);
    assign frame_last = (oh == OM1) && (ow == OM1);

    pool2_row_offset #(
        .IN_W  (IN_W),
        .ADDR_W(ADDR_W),
        .ROW_W (8)
    ) u_row_offset (
        .row (row),
        .base(row_base)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= IDLE;
            oh       <= '0;
            ow       <= '0;
            kh       <= '0;
            kw       <= '0;
            idx      <= '0;
            rd_vld   <= 1'b0;
            rd_first <= 1'b0;
            mx       <= '0;
        end else begin
            state    <= state_nx;
            // Read data lags in_ce by one cycle, so the window-first flag travels with it.
            rd_vld   <= (state == ISSUE);
            rd_first <= (state == ISSUE) && (kh == '0) && (kw == '0);
            if (rd_vld && (rd_first || ($signed(in_q) > mx))) begin
                mx <= in_q;
            end

            case (state)
                IDLE: begin
                    if (ap_start) begin
                        oh  <= '0;
                        ow  <= '0;
                        kh  <= '0;
                        kw  <= '0;
                        idx <= '0;
                    end
                end
                ISSUE: begin
                    if (kw == KM1) begin
                        kw <= '0;
                        kh <= (kh == KM1) ? '0 : kh + 8'd1;
                    end else begin
                        kw <= kw + 8'd1;
                    end
                end
                EMIT: begin
                    if (out_ready && !frame_last) begin
                        idx <= idx + 8'd1;
                        if (ow == OM1) begin
                            ow <= '0;
                            oh <= oh + 8'd1;
                        end else begin
                            ow <= ow + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        ap_idle   = 1'b0;
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        in_ce     = 1'b0;
        in_addr   = '0;
        out_valid = 1'b0;
        out_data  = mx;
        out_idx   = idx;

        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nx = ISSUE;
            end
            ISSUE: begin
                in_ce   = 1'b1;
                in_addr = rd_addr;
                if (win_last) state_nx = DRAIN;
            end
            DRAIN: begin
                state_nx = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = frame_last ? DONE : ISSUE;
            end
            DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs show their reset values from the first reset cycle, not one edge later.
        if (ap_rst) begin
            ap_idle   = 1'b1;
            ap_ready  = 1'b0;
            ap_done   = 1'b0;
            in_ce     = 1'b0;
            in_addr   = '0;
            out_valid = 1'b0;
            out_data  = '0;
            out_idx   = '0;
        end
    end

endmodule

// File: tb/tb_pool2_window_max.sv
// Scoreboarded random bench for pool2_window_max: a behavioural max-pool
// model queues expected outputs; a monitor pops and compares on handshakes.
module tb_pool2_window_max;

    localparam int IN_W    = 27;
    localparam int K       = 3;
    localparam int S       = 2;
    localparam int OUT_W   = 13;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 10;
    localparam int NOUT    = OUT_W * OUT_W;
    localparam int WIN_CYC = K * K + 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic              ap_start = 1'b0;
    logic              ap_idle, ap_ready, ap_done;
    logic [ADDR_W-1:0] in_addr;
    logic              in_ce;
    logic [DATA_W-1:0] in_q = '0;
    logic [DATA_W-1:0] out_data;
    logic [7:0]        out_idx;
    logic              out_valid;
    logic              out_ready = 1'b1;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem[1024];
    int          vec = 0;
    int          errs = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    bit          exp_done_next = 1'b0;

    pool2_window_max #(
        .IN_W  (IN_W),
        .K     (K),
        .S     (S),
        .OUT_W (OUT_W),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .ap_done  (ap_done),
        .in_addr  (in_addr),
        .in_ce    (in_ce),
        .in_q     (in_q),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    // Input buffer: one-cycle read latency.
    always @(posedge ap_clk) begin
        if (in_ce) in_q <= mem[in_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_idle"},      32'(ap_idle),   32'd1);
        check({tag, "_ready"},     32'(ap_ready),  32'd0);
        check({tag, "_done"},      32'(ap_done),   32'd0);
        check({tag, "_in_ce"},     32'(in_ce),     32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_addr"},   32'(in_addr),   32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_idx"},   32'(out_idx),   32'd0);
    endtask

    // Reference: each output is the signed maximum of its KxK window.
    function automatic void push_expected();
        for (int oh = 0; oh < OUT_W; oh++) begin
            for (int ow = 0; ow < OUT_W; ow++) begin
                int   best;
                exp_t e;
                best = 0;
                for (int kh = 0; kh < K; kh++) begin
                    for (int kw = 0; kw < K; kw++) begin
                        int a;
                        int v;
                        a = (oh * S + kh) * IN_W + ow * S + kw;
                        v = $signed(mem[a]);
                        if ((kh == 0 && kw == 0) || v > best) best = v;
                    end
                end
                e.idx  = oh * OUT_W + ow;
                e.data = 16'(best);
                q.push_back(e);
            end
        end
    endfunction

    task automatic fill(input int mode);
        for (int a = 0; a < 1024; a++) begin
            case (mode)
                0:       mem[a] = 16'(a);
                1:       mem[a] = (a == 28) ? 16'h7FFF : 16'hFFFB;
                2:       mem[a] = 16'h8000;
                default: mem[a] = 16'($urandom_range(0, 65535));
            endcase
        end
    endtask

    task automatic start_frame();
        push_expected();
        hs_cnt = 0;
        @(posedge ap_clk); #1 ap_start = 1'b1;
        @(posedge ap_clk); #1 ap_start = 1'b0;
    endtask

    task automatic wait_frame(input bit rand_ready, output int cycles);
        cycles = 0;
        forever begin
            @(negedge ap_clk);
            if (ap_done) break;
            cycles++;
            if (cycles > 8000) begin
                vec++;
                errs++;
                $display("FAIL frame_timeout: got no ap_done, want ap_done within 8000 cycles");
                break;
            end
            if (rand_ready) begin
                @(posedge ap_clk);
                #1 out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        check("outputs_per_frame", 32'(hs_cnt), 32'(NOUT));
        check("queue_drained", 32'(q.size()), 32'd0);
    endtask

    // Monitor: scoreboard compare on every accepted output, ap_done timing.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (exp_done_next) begin
                check("done_after_last", 32'(ap_done), 32'd1);
                check("ready_with_done", 32'(ap_ready), 32'd1);
            end else if (ap_done) begin
                check("unexpected_done", 32'(ap_done), 32'd0);
            end
            exp_done_next = 1'b0;
            if (ap_done) done_cnt++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_idx", 32'(out_idx), 32'(e.idx));
                    check("out_data", 32'(out_data), 32'(e.data));
                    if (e.idx == NOUT - 1) exp_done_next = 1'b1;
                end
                hs_cnt++;
            end
        end else begin
            exp_done_next = 1'b0;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cyc;
        int          cnt;
        int          d0;
        int          idle_bad;
        logic [15:0] sd;
        logic [7:0]  si;

        fill(3);
        repeat (3) @(negedge ap_clk);
        check_reset_outputs("reset");
        @(posedge ap_clk); #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        check("idle_after_reset", 32'(ap_idle), 32'd1);

        // Address-valued pixels: every window max is its bottom-right pixel.
        fill(0);
        start_frame();
        wait_frame(1'b0, cyc);
        check("frame_cycles", 32'(cyc), 32'(NOUT * WIN_CYC));

        fill(1);
        start_frame();
        wait_frame(1'b0, cyc);

        fill(2);
        start_frame();
        wait_frame(1'b0, cyc);

        // Back-pressure: hold the first output for 10 cycles, then random ready.
        fill(3);
        out_ready = 1'b0;
        start_frame();
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge ap_clk); #1;
            cnt++;
        end
        check("stall_valid_seen", 32'(out_valid), 32'd1);
        check("stall_first_idx", 32'(out_idx), 32'd0);
        sd = out_data;
        si = out_idx;
        repeat (10) begin
            @(negedge ap_clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(sd));
            check("stall_idx", 32'(out_idx), 32'(si));
            check("stall_no_ce", 32'(in_ce), 32'd0);
        end
        @(posedge ap_clk); #1 out_ready = 1'b1;
        wait_frame(1'b1, cyc);

        // Reset on the 5th read of the third window, then a clean frame.
        fill(3);
        start_frame();
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 2 * K * K + 5; c++) begin
            @(posedge ap_clk); #1;
            if (in_ce) cnt++;
        end
        check("reached_reset_point", 32'(cnt), 32'(2 * K * K + 5));
        ap_rst = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            check_reset_outputs("midreset");
        end
        @(posedge ap_clk); #1 ap_rst = 1'b0;
        q.delete();
        @(negedge ap_clk);
        check("midreset_idle", 32'(ap_idle), 32'd1);
        check("midreset_no_valid", 32'(out_valid), 32'd0);
        fill(3);
        start_frame();
        wait_frame(1'b0, cyc);
        check("frame_cycles_after_reset", 32'(cyc), 32'(NOUT * WIN_CYC));

        // ap_start pulses during ISSUE and EMIT must be ignored.
        fill(3);
        d0 = done_cnt;
        start_frame();
        cnt = 0;
        while (!in_ce && cnt < 50) begin
            @(posedge ap_clk); #1;
            cnt++;
        end
        ap_start = 1'b1;
        @(posedge ap_clk); #1 ap_start = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(posedge ap_clk); #1;
            cnt++;
        end
        check("pulse_emit_seen", 32'(out_valid), 32'd1);
        ap_start = 1'b1;
        @(posedge ap_clk); #1 ap_start = 1'b0;
        wait_frame(1'b0, cyc);
        check("single_done", 32'(done_cnt - d0), 32'd1);
        idle_bad = 0;
        repeat (20) begin
            @(negedge ap_clk);
            if (!ap_idle || in_ce || out_valid) idle_bad++;
        end
        check("stays_idle", 32'(idle_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
